// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the fetch unit and its next-PC logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  // Fetch sequencing: one instruction in flight at a time.
  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction field bit positions.
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Next-PC selection: jump > taken branch > sequential.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to load the result.
// Ports: pc_plus4/imm16/target/branch/jump/zero in, next_pc out.
module next_pc_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Word offset sign-extended and scaled to bytes; adds wrap modulo 2^32.
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  // Jump keeps the 256 MB region of the following instruction.
  assign jump_target   = {pc_plus4[31:28], target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC, fetches over req/ack, holds IR and splits fields.
// Latency: 1 RST cycle after reset release, then FETCH (>=1 cycle, until ack) + EXEC (>=1 cycle).
// Backpressure: imem_req held until imem_ack; stall holds EXEC with pc/IR frozen.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ack/imem_rdata memory port;
//        branch/jump/zero/stall from control; instr + fields, pc, pc_plus4, instr_valid out.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  state_t      state;
  state_t      state_nxt;
  logic        load_ir;
  logic        load_pc;
  logic [31:0] next_pc;
  logic [31:0] ir;

  // State register; async reset drops imem_req/instr_valid immediately
  // because both are decoded from state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    case (state)
      RST: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          load_pc   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= NOP_INSTR;
    end else begin
      if (load_pc) begin
        pc <= next_pc;
      end
      if (load_ir) begin
        ir <= imem_rdata;
      end
    end
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  assign instr  = ir;
  assign op     = ir[OP_MSB:OP_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign rt     = ir[RT_MSB:RT_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign shamt  = ir[SHAMT_MSB:SHAMT_LSB];
  assign func   = ir[FUNC_MSB:FUNC_LSB];
  assign imm16  = ir[IMM_MSB:IMM_LSB];
  assign target = ir[TARGET_MSB:TARGET_LSB];

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .imm16    (imm16),
    .target   (target),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed sequence with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch, jump, zero, stall;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] pc, pc_plus4;
  logic        instr_valid;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .stall       (stall),
    .instr       (instr),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .func        (func),
    .imm16       (imm16),
    .target      (target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks only "what the unit is doing": waiting for a word, or holding one.
  logic [31:0] m_pc, m_ir;
  logic        m_waiting, m_holding;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic b, input logic j, input logic z);
    logic [31:0] seq, tgt, off;
    seq = cur + 32'd4;
    tgt = word & 32'h03FF_FFFF;
    off = {16'(0), word[15:0]};
    if (word[15]) off = off - 32'h0001_0000;   // signed 16-bit value as 32-bit
    if (j)            return (seq & 32'hF000_0000) | (tgt * 32'd4);
    else if (b && z)  return seq + off * 32'd4;
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= RPC;
      m_ir      <= 32'h0;
      m_waiting <= 1'b0;
      m_holding <= 1'b0;
    end else if (m_holding) begin
      if (!stall) begin
        m_pc      <= model_next(m_pc, m_ir, branch, jump, zero);
        m_holding <= 1'b0;
        m_waiting <= 1'b1;
      end
    end else if (m_waiting) begin
      if (imem_ack) begin
        m_ir      <= imem_rdata;
        m_waiting <= 1'b0;
        m_holding <= 1'b1;
      end
    end else begin
      m_waiting <= 1'b1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_req",    {31'b0, imem_req},    {31'b0, m_waiting});
      chk("m_valid",  {31'b0, instr_valid}, {31'b0, m_holding});
      chk("m_pc",     pc,       m_pc);
      chk("m_pc4",    pc_plus4, m_pc + 32'd4);
      chk("m_instr",  instr,    m_ir);
      if (m_waiting) chk("m_addr", imem_addr, m_pc);
      chk("m_op",     {26'b0, op},     (m_ir >> 26) & 32'h3F);
      chk("m_rs",     {27'b0, rs},     (m_ir >> 21) & 32'h1F);
      chk("m_rt",     {27'b0, rt},     (m_ir >> 16) & 32'h1F);
      chk("m_rd",     {27'b0, rd},     (m_ir >> 11) & 32'h1F);
      chk("m_shamt",  {27'b0, shamt},  (m_ir >> 6)  & 32'h1F);
      chk("m_func",   {26'b0, func},   m_ir & 32'h3F);
      chk("m_imm",    {16'b0, imm16},  m_ir & 32'hFFFF);
      chk("m_target", {6'b0, target},  m_ir & 32'h03FF_FFFF);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: deliver word with zero wait, execute with the given
  // control, and return in the next FETCH cycle.
  task automatic fetch_exec(input logic [31:0] word, input logic b, input logic j, input logic z);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; branch = b; jump = j; zero = z; stall = 1'b0;
    step();
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0; stall = 1'b0;

    #3;
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc",    pc,    32'h0);
    chk("rst_instr", instr, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    chk("zw_valid", {31'b0, instr_valid}, 32'd1);
    chk("zw_op",    {26'b0, op},    32'h08);
    chk("zw_rt",    {27'b0, rt},    32'd8);
    chk("zw_imm",   {16'b0, imm16}, 32'h5);
    imem_ack = 1'b0;
    step();
    chk("seq_addr", imem_addr, 32'h4);

    fetch_exec(32'h0800_0004, 1'b0, 1'b1, 1'b0);
    chk("j_to_10", imem_addr, 32'h10);
    fetch_exec(32'h1000_FFFC, 1'b1, 1'b0, 1'b1);
    chk("br_taken", imem_addr, 32'h04);
    fetch_exec(32'h0800_0004, 1'b0, 1'b1, 1'b0);
    fetch_exec(32'h1000_FFFC, 1'b1, 1'b0, 1'b0);
    chk("br_not_taken", imem_addr, 32'h14);
    fetch_exec(32'h1000_FFF9, 1'b1, 1'b0, 1'b1);
    chk("br_back_wrap", imem_addr, 32'hFFFF_FFFC);
    fetch_exec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", imem_addr, 32'h0);
    fetch_exec(32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0);
    chk("j_max", imem_addr, 32'h0FFF_FFFC);
    fetch_exec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    fetch_exec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    fetch_exec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    chk("reach_1008", imem_addr, 32'h1000_0008);
    fetch_exec(32'h0800_0040, 1'b1, 1'b1, 1'b1);
    chk("jump_wins", imem_addr, 32'h1000_0100);

    // Three wait states.
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",   {31'b0, imem_req},    32'd1);
      chk("ws_addr",  imem_addr,            32'h1000_0100);
      chk("ws_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
    step();
    // Two stalled edges; a stray ack must not disturb IR.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("st_valid", {31'b0, instr_valid}, 32'd1);
      chk("st_req",   {31'b0, imem_req},    32'd0);
      chk("st_pc",    pc,    32'h1000_0100);
      chk("st_instr", instr, 32'h0123_4567);
      step();
    end
    chk("st_instr_end", instr, 32'h0123_4567);
    imem_ack = 1'b0; stall = 1'b0;
    step();
    chk("after_stall", imem_addr, 32'h1000_0104);

    // Async reset mid-FETCH with an ack pending.
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    #2; rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},    32'd0);
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_pc",    pc,    RPC);
    step(); step();
    rst_n = 1'b1; imem_ack = 1'b0;
    step();
    chk("ar_refetch_req",  {31'b0, imem_req}, 32'd1);
    chk("ar_refetch_addr", imem_addr, RPC);

    // Randomized traffic, including occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst_n == 1'b0) rst_n = 1'b1;
      imem_ack   = ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom;
      jump       = ($urandom_range(0, 4) == 0);
      branch     = $urandom_range(0, 1) == 1;
      zero       = $urandom_range(0, 1) == 1;
      stall      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2; rst_n = 1'b0;
      end
    end
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
